// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared constants and FSM state type for the fetch-side
// PC/NPC sequencer.
//   DEF_ADDR_W      - default PC/NPC/target width
//   DEF_INSTR_BYTES - default sequential fetch increment
//   DEF_RESET_PC    - default PC after reset
//   state_t         - sequencer FSM states (RUN, HOLD_PEND)
package pc_sequencer_pkg;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_INSTR_BYTES = 4;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_HOLD_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: branch-decision inputs and fetch-address/squash outputs of
// the PC/NPC sequencer.
//   master : drives le, j, ex_valid, ta, n_bit; observes pc, npc, squashes
//   slave  : the sequencer itself
// Build option: ALIGN_CHECK_EN adds the misalign_trap signal.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              le;
  logic              j;
  logic              ex_valid;
  logic [ADDR_W-1:0] ta;
  logic              n_bit;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic              flush_if;
  logic              nullify_ds;
  logic              redirect_pend;
`ifdef ALIGN_CHECK_EN
  logic              misalign_trap;
`endif

  modport master (
    output le, j, ex_valid, ta, n_bit,
`ifdef ALIGN_CHECK_EN
    input  misalign_trap,
`endif
    input  pc, npc, flush_if, nullify_ds, redirect_pend
  );

  modport slave (
    input  le, j, ex_valid, ta, n_bit,
`ifdef ALIGN_CHECK_EN
    output misalign_trap,
`endif
    output pc, npc, flush_if, nullify_ds, redirect_pend
  );
endinterface

// File: rtl/pc_sequencer_pc_npc_reg.sv
// pc_npc_reg: PC/NPC register pair.
//   clk, rst_n : clock, asynchronous active-low reset
//   adv        : sequential advance (pc <= npc, npc <= npc + INSTR_BYTES)
//   load       : redirect (pc <= target, npc <= target + INSTR_BYTES); wins over adv
//   target     : redirect address
//   pc, npc    : current and next fetch address
// Increments wrap modulo 2^ADDR_W.
module pc_npc_reg #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       INSTR_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INSTR_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      npc <= RESET_PC + INC;
    end else if (load) begin
      pc  <= target;
      npc <= target + INC;
    end else if (adv) begin
      pc  <= npc;
      npc <= npc + INC;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side PC/NPC sequencer downstream of the condition handler.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : pc_sequencer_if.slave
//     le         advance enable (0 = stall, hold everything)
//     j/ex_valid jump decision and its qualifier from EX
//     ta/n_bit   branch target and nullify bit from EX
//     pc/npc     fetch address pair
//     flush_if   squash IF/ID next edge (combinational from the applied redirect)
//     nullify_ds squash ID/EX next edge (delay slot nullified)
//     redirect_pend a taken branch is held awaiting le
// Build option: ALIGN_CHECK_EN adds misalign_trap, pulsed on an applied redirect
// whose target has non-zero low bits. Target low bits are always forced to 00.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned       INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state;
  logic [ADDR_W-1:0] pend_ta;
  logic              pend_n;
  logic              redirect_pend_q;

  logic              take;
  logic              holding;
  logic              apply;
  logic [ADDR_W-1:0] sel_ta;
  logic              sel_n;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] npc_q;

  // While a redirect is pending, the latched copy is the only source; a fresh
  // take in the release cycle belongs to the wrong-path instruction being flushed.
  always_comb begin
    take    = bus.j & bus.ex_valid;
    holding = (state == ST_HOLD_PEND);
    apply   = bus.le & (holding | take);
    sel_ta  = holding ? pend_ta : bus.ta;
    sel_n   = holding ? pend_n  : bus.n_bit;
    target  = sel_ta & ALIGN_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_RUN;
      pend_ta         <= '0;
      pend_n          <= 1'b0;
      redirect_pend_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!bus.le && take) begin
            state           <= ST_HOLD_PEND;
            pend_ta         <= bus.ta;
            pend_n          <= bus.n_bit;
            redirect_pend_q <= 1'b1;
          end
        end
        ST_HOLD_PEND: begin
          if (bus.le) begin
            state           <= ST_RUN;
            redirect_pend_q <= 1'b0;
          end
        end
        default: begin
          state           <= ST_RUN;
          redirect_pend_q <= 1'b0;
        end
      endcase
    end
  end

  pc_npc_reg #(
    .ADDR_W      (ADDR_W),
    .RESET_PC    (RESET_PC),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pc_npc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv    (bus.le),
    .load   (apply),
    .target (target),
    .pc     (pc_q),
    .npc    (npc_q)
  );

  assign bus.pc            = pc_q;
  assign bus.npc           = npc_q;
  assign bus.flush_if      = apply;
  assign bus.nullify_ds    = apply & sel_n;
  assign bus.redirect_pend = redirect_pend_q;
`ifdef ALIGN_CHECK_EN
  assign bus.misalign_trap = apply & (|sel_ta[1:0]);
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized bench for pc_sequencer, checked
// against a behavioural model (pc plus a pending-redirect queue) on every cycle.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(
    .ADDR_W      (32),
    .RESET_PC    (32'h0000_0000),
    .INSTR_BYTES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: npc is always pc+4; a stalled taken branch sits in a queue.
  typedef struct {
    logic [31:0] ta;
    logic        n;
  } pend_t;

  logic [31:0] m_pc;
  pend_t       m_pend[$];
  bit          m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    = 32'h0;
      m_pend.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_pend.size() != 0) begin
        if (bus.le) begin
          m_pc = m_pend[0].ta & ~32'h3;
          m_pend.delete();
        end
      end else if (bus.le) begin
        if (bus.j && bus.ex_valid) m_pc = bus.ta & ~32'h3;
        else                       m_pc = m_pc + 32'd4;
      end else if (bus.j && bus.ex_valid) begin
        m_pend.push_back('{ta: bus.ta, n: bus.n_bit});
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid && rst_n === 1'b1) begin
      logic        e_flush;
      logic        e_null;
      logic [31:0] e_ta;
      e_flush = bus.le && (m_pend.size() != 0 || (bus.j && bus.ex_valid));
      e_ta    = (m_pend.size() != 0) ? m_pend[0].ta : bus.ta;
      e_null  = e_flush && ((m_pend.size() != 0) ? m_pend[0].n : bus.n_bit);
      chk("m_pc", bus.pc, m_pc);
      chk("m_npc", bus.npc, m_pc + 32'd4);
      chk("m_flush_if", 32'(bus.flush_if), 32'(e_flush));
      chk("m_nullify_ds", 32'(bus.nullify_ds), 32'(e_null));
      chk("m_redirect_pend", 32'(bus.redirect_pend), 32'(m_pend.size() != 0));
`ifdef ALIGN_CHECK_EN
      chk("m_misalign_trap", 32'(bus.misalign_trap), 32'(e_flush && (e_ta[1:0] != 2'b00)));
`else
      if (e_ta[1:0] == 2'b11 && e_flush) chk("m_target_aligned", bus.npc & 32'h3, 32'h0);
`endif
    end
  end

  task automatic set_in(input logic le, input logic j, input logic ev,
                        input logic [31:0] ta, input logic n);
    bus.le       = le;
    bus.j        = j;
    bus.ex_valid = ev;
    bus.ta       = ta;
    bus.n_bit    = n;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) next_cycle();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_npc", bus.npc, 32'h4);
    chk("rst_flush", 32'(bus.flush_if), 32'h0);
    chk("rst_nullify", 32'(bus.nullify_ds), 32'h0);
    chk("rst_pend", 32'(bus.redirect_pend), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_valid = 1'b0;
    rst_n   = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;

    // Sequential fetch from reset
    do_reset();
    bus.le = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("seq_pc", bus.pc, 32'(4 * i));
      chk("seq_npc", bus.npc, 32'(4 * i + 4));
      chk("seq_flush", 32'(bus.flush_if), 32'h0);
      next_cycle();
    end

    // Taken branch at pc=8, n_bit=0
    do_reset();
    bus.le = 1'b1;
    repeat (2) next_cycle();
    set_in(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    @(negedge clk);
    chk("br_pc8", bus.pc, 32'h8);
    chk("br_flush", 32'(bus.flush_if), 32'h1);
    chk("br_null0", 32'(bus.nullify_ds), 32'h0);
    next_cycle();
    set_in(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    chk("br_pc_tgt", bus.pc, 32'h100);
    chk("br_npc_tgt", bus.npc, 32'h104);
    chk("br_flush_off", 32'(bus.flush_if), 32'h0);

    // Taken branch with n_bit=1
    next_cycle();
    set_in(1'b1, 1'b1, 1'b1, 32'h180, 1'b1);
    @(negedge clk);
    chk("brn_flush", 32'(bus.flush_if), 32'h1);
    chk("brn_null", 32'(bus.nullify_ds), 32'h1);
    next_cycle();
    set_in(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    chk("brn_flush_off", 32'(bus.flush_if), 32'h0);
    chk("brn_null_off", 32'(bus.nullify_ds), 32'h0);
    chk("brn_pc", bus.pc, 32'h180);
    next_cycle();

    // Branch during stall; target input changes are ignored while pending
    set_in(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    @(negedge clk);
    chk("st_flush0", 32'(bus.flush_if), 32'h0);
    chk("st_pc", bus.pc, 32'h184);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      chk("st_pend", 32'(bus.redirect_pend), 32'h1);
      chk("st_pc_hold", bus.pc, 32'h184);
      chk("st_no_flush", 32'(bus.flush_if), 32'h0);
    end
    next_cycle();
    set_in(1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
    @(negedge clk);
    chk("st_rel_flush", 32'(bus.flush_if), 32'h1);
    chk("st_rel_null", 32'(bus.nullify_ds), 32'h1);
    next_cycle();
    set_in(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    chk("st_pc_tgt", bus.pc, 32'h200);
    chk("st_npc_tgt", bus.npc, 32'h204);
    chk("st_pend_clr", 32'(bus.redirect_pend), 32'h0);
    chk("st_flush_off", 32'(bus.flush_if), 32'h0);
    next_cycle();

    // j without ex_valid is not a redirect
    set_in(1'b1, 1'b1, 1'b0, 32'h400, 1'b1);
    @(negedge clk);
    chk("ev0_flush", 32'(bus.flush_if), 32'h0);
    next_cycle();
    set_in(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    chk("ev0_pc", bus.pc, 32'h208);
    next_cycle();

    // Reset during HOLD_PEND discards the pending redirect
    set_in(1'b0, 1'b1, 1'b1, 32'h500, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("rh_pend", 32'(bus.redirect_pend), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rh_pc", bus.pc, 32'h0);
    chk("rh_npc", bus.npc, 32'h4);
    chk("rh_pend_clr", 32'(bus.redirect_pend), 32'h0);
    set_in(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rh_pc_after", bus.pc, 32'h0);
    next_cycle();

    // Misaligned target: low bits forced to 00
    set_in(1'b1, 1'b1, 1'b1, 32'h102, 1'b0);
    @(negedge clk);
    chk("al_flush", 32'(bus.flush_if), 32'h1);
`ifdef ALIGN_CHECK_EN
    chk("al_trap", 32'(bus.misalign_trap), 32'h1);
`endif
    next_cycle();
    set_in(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    chk("al_pc", bus.pc, 32'h100);
    chk("al_npc", bus.npc, 32'h104);
`ifdef ALIGN_CHECK_EN
    chk("al_trap_off", 32'(bus.misalign_trap), 32'h0);
`endif
    next_cycle();

    // Address wrap
    set_in(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    next_cycle();
    set_in(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    chk("wr_pc", bus.pc, 32'hFFFF_FFFC);
    chk("wr_npc", bus.npc, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("wr_pc0", bus.pc, 32'h0);
    chk("wr_npc4", bus.npc, 32'h4);
    next_cycle();

    // Randomized traffic, occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] rta;
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      rta   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) != 0, rta, 1'($urandom_range(0, 1)));
      next_cycle();
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
